// File: rtl/poker_shoe.sv
// rtl/poker_shoe.sv - multi-deck card shoe with LFSR-driven Fisher-Yates shuffle
module poker_shoe #(
  parameter int                NUM_DECKS    = 1,
  parameter int                CUT_REMAIN   = 10,
  parameter int                SEED_W       = 16,
  parameter logic [SEED_W-1:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              deal,
  input  logic              shuffle,
  input  logic [SEED_W-1:0] seed,
  output logic              dealt,
  output logic [3:0]        rank,
  output logic [1:0]        suit,
  output logic              shuffled,
  output logic              busy,
  output logic [7:0]        remaining,
  output logic              low_shoe,
  output logic              err
);

  localparam int N     = 52 * NUM_DECKS;
  localparam int IDX_W = $clog2(N);
  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
  localparam logic [SEED_W-1:0] LFSR_TAPS = SEED_W'(16'hB400);
  localparam logic LOW_AT_FULL = (N <= CUT_REMAIN);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DEAL,
    S_SH_DRAW,
    S_SH_SWAP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [5:0]        r_mem [0:N-1];
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_i;
  logic [IDX_W-1:0]  r_j;
  logic [SEED_W-1:0] r_lfsr;
  logic [3:0]        r_init_rank;
  logic [1:0]        r_init_suit;
  logic [7:0]        r_remaining;
  logic [3:0]        r_rank;
  logic [1:0]        r_suit;
  logic              r_dealt;
  logic              r_shuffled;
  logic              r_err;
  logic              r_busy;
  logic              r_low_shoe;

  logic              w_do_deal;
  logic              w_do_shuffle;
  logic              w_reject;
  logic              w_init_done;
  logic              w_draw_ok;
  logic              w_swap_done;
  logic [IDX_W-1:0]  w_j;
  logic [SEED_W-1:0] w_lfsr_next;
  logic [7:0]        w_remaining_dec;

  assign w_j             = r_lfsr[IDX_W-1:0];
  assign w_lfsr_next     = {1'b0, r_lfsr[SEED_W-1:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0);
  assign w_remaining_dec = r_remaining - 8'd1;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_next;
  end

  // Next-state decode and request arbitration; only IDLE accepts requests
  always_comb begin
    w_next       = r_state;
    w_do_deal    = 1'b0;
    w_do_shuffle = 1'b0;
    w_reject     = 1'b0;
    w_init_done  = 1'b0;
    w_draw_ok    = 1'b0;
    w_swap_done  = 1'b0;
    case (r_state)
      S_INIT: begin
        w_reject = deal | shuffle;
        if (r_ptr == IDX_W'(N - 1)) begin
          w_init_done = 1'b1;
          w_next      = S_IDLE;
        end
      end
      S_IDLE: begin
        if (shuffle) begin
          w_do_shuffle = 1'b1;
          w_reject     = deal;
          w_next       = S_SH_DRAW;
        end else if (deal) begin
          if (r_remaining != 8'd0) begin
            w_do_deal = 1'b1;
            w_next    = S_DEAL;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_DEAL: begin
        w_reject = deal | shuffle;
        w_next   = S_IDLE;
      end
      S_SH_DRAW: begin
        w_reject = deal | shuffle;
        if (w_j <= r_i) begin
          w_draw_ok = 1'b1;
          w_next    = S_SH_SWAP;
        end
      end
      S_SH_SWAP: begin
        w_reject = deal | shuffle;
        if (r_i == IDX_W'(1)) begin
          w_swap_done = 1'b1;
          w_next      = S_IDLE;
        end else begin
          w_next = S_SH_DRAW;
        end
      end
      default: w_next = S_INIT;
    endcase
  end

  // Control datapath: pointers, counters, LFSR and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_lfsr      <= DEFAULT_SEED;
      r_init_rank <= 4'd1;
      r_init_suit <= 2'd0;
      r_remaining <= 8'd0;
      r_rank      <= 4'd0;
      r_suit      <= 2'd0;
      r_dealt     <= 1'b0;
      r_shuffled  <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b1;
      r_low_shoe  <= 1'b0;
    end else begin
      r_dealt    <= w_do_deal;
      r_shuffled <= w_swap_done;
      r_err      <= w_reject;
      if (r_state == S_INIT) begin
        // suit counter wraps 3->0 naturally, which also rolls into the next deck
        if (r_init_rank == 4'd13) begin
          r_init_rank <= 4'd1;
          r_init_suit <= r_init_suit + 2'd1;
        end else begin
          r_init_rank <= r_init_rank + 4'd1;
        end
        r_ptr <= w_init_done ? '0 : r_ptr + IDX_W'(1);
      end
      if (w_init_done || w_swap_done) begin
        r_ptr       <= '0;
        r_remaining <= 8'(N);
        r_busy      <= 1'b0;
        r_low_shoe  <= LOW_AT_FULL;
      end
      if (w_do_deal) begin
        {r_rank, r_suit} <= r_mem[r_ptr];
        r_ptr            <= r_ptr + IDX_W'(1);
        r_remaining      <= w_remaining_dec;
        r_low_shoe       <= (w_remaining_dec <= 8'(CUT_REMAIN));
      end
      if (w_do_shuffle) begin
        r_lfsr <= (seed == '0) ? DEFAULT_SEED : seed;
        r_i    <= IDX_W'(N - 1);
        r_busy <= 1'b1;
      end
      if (r_state == S_SH_DRAW) begin
        r_lfsr <= w_lfsr_next;
        if (w_draw_ok) r_j <= w_j;
      end
      if ((r_state == S_SH_SWAP) && !w_swap_done) r_i <= r_i - IDX_W'(1);
    end
  end

  // Card array: ordered fill during INIT, in-place swap during shuffle
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_ptr] <= {r_init_rank, r_init_suit};
    end else if (r_state == S_SH_SWAP) begin
      r_mem[r_i] <= r_mem[r_j];
      r_mem[r_j] <= r_mem[r_i];
    end
  end

  assign dealt     = r_dealt;
  assign rank      = r_rank;
  assign suit      = r_suit;
  assign shuffled  = r_shuffled;
  assign busy      = r_busy;
  assign remaining = r_remaining;
  assign low_shoe  = r_low_shoe;
  assign err       = r_err;

endmodule

// File: tb/tb_poker_shoe.sv
// tb/tb_poker_shoe.sv - directed self-checking bench for poker_shoe
module tb_poker_shoe;

  localparam int NUM_DECKS = 2;
  localparam int N         = 52 * NUM_DECKS;
  localparam int CUT       = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        deal = 1'b0;
  logic        shuffle = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic        dealt;
  logic [3:0]  rank;
  logic [1:0]  suit;
  logic        shuffled;
  logic        busy;
  logic [7:0]  remaining;
  logic        low_shoe;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_seq [N];
  logic [5:0] got_seq [N];
  logic [5:0] seq_a   [N];
  int         exp_draws;
  int         init_cycles;
  int         got_cycles;
  bit         got_timeout;
  bit         got_busy_at_done;
  bit         got_all_dealt;

  poker_shoe #(
    .NUM_DECKS   (NUM_DECKS),
    .CUT_REMAIN  (CUT),
    .SEED_W      (16),
    .DEFAULT_SEED(16'hACE1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .deal     (deal),
    .shuffle  (shuffle),
    .seed     (seed),
    .dealt    (dealt),
    .rank     (rank),
    .suit     (suit),
    .shuffled (shuffled),
    .busy     (busy),
    .remaining(remaining),
    .low_shoe (low_shoe),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Reference: ordered card k of the shoe
  function automatic logic [5:0] ordered_card(input int k);
    int c;
    c = k % 52;
    return {4'(c % 13 + 1), 2'(c / 13)};
  endfunction

  // Reference Fisher-Yates over an ordered shoe driven by the Galois LFSR
  task automatic model_shuffle(input logic [15:0] s);
    logic [5:0]  m [N];
    logic [5:0]  tmp;
    logic [15:0] l;
    int          j;
    for (int k = 0; k < N; k++) m[k] = ordered_card(k);
    l = (s == 16'h0000) ? 16'hACE1 : s;
    exp_draws = 0;
    for (int i = N - 1; i >= 1; i--) begin
      do begin
        j = int'(l[6:0]);
        l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
        exp_draws++;
      end while (j > i && exp_draws < 100000);
      tmp = m[i]; m[i] = m[j]; m[j] = tmp;
    end
    for (int k = 0; k < N; k++) exp_seq[k] = m[k];
  endtask

  task automatic do_reset_init();
    int cnt;
    @(negedge clk);
    reset = 1'b0; deal = 1'b0; shuffle = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    while (busy && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    init_cycles = cnt;
  endtask

  task automatic run_shuffle_deal(input logic [15:0] s);
    int cnt;
    do_reset_init();
    seed = s; shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0; seed = 16'hFFFF;
    cnt = 1;
    while (!shuffled && cnt < 6000) begin
      @(negedge clk);
      cnt++;
    end
    got_cycles       = cnt;
    got_timeout      = !shuffled;
    got_busy_at_done = busy;
    got_all_dealt    = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      deal = 1'b1;
      @(negedge clk);
      deal = 1'b0;
      if (!dealt) got_all_dealt = 1'b0;
      got_seq[k] = {rank, suit};
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || dealt !== 1'b0 || shuffled !== 1'b0 || err !== 1'b0)
      begin n_fail++; $display("FAIL reset_ctrl: busy=%b dealt=%b shuffled=%b err=%b, expected 1 0 0 0", busy, dealt, shuffled, err); end
    n_checks++;
    if (rank !== 4'd0 || suit !== 2'd0 || remaining !== 8'd0 || low_shoe !== 1'b0)
      begin n_fail++; $display("FAIL reset_data: rank=%0d suit=%0d remaining=%0d low=%b, expected 0 0 0 0", rank, suit, remaining, low_shoe); end
    do_reset_init();
    n_checks++;
    if (init_cycles != N)
      begin n_fail++; $display("FAIL init_busy_cycles: got %0d expected %0d", init_cycles, N); end
    n_checks++;
    if (remaining !== 8'(N) || low_shoe !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL init_done: remaining=%0d low=%b busy=%b, expected %0d 0 0", remaining, low_shoe, busy, N); end
  endtask

  task automatic test_ordered_deal();
    int exp_rem;
    for (int k = 0; k < N; k++) begin
      exp_rem = N - 1 - k;
      deal = 1'b1;
      @(negedge clk);
      deal = 1'b0;
      n_checks++;
      if (dealt !== 1'b1 || {rank, suit} !== ordered_card(k))
        begin n_fail++; $display("FAIL ordered_card[%0d]: dealt=%b card=%h expected dealt=1 card=%h", k, dealt, {rank, suit}, ordered_card(k)); end
      n_checks++;
      if (remaining !== 8'(exp_rem) || low_shoe !== (exp_rem <= CUT))
        begin n_fail++; $display("FAIL ordered_remaining[%0d]: remaining=%0d low=%b expected %0d %b", k, remaining, low_shoe, exp_rem, exp_rem <= CUT); end
      @(negedge clk);
      n_checks++;
      if (dealt !== 1'b0)
        begin n_fail++; $display("FAIL dealt_pulse[%0d]: dealt=%b expected 0", k, dealt); end
    end
  endtask

  task automatic test_empty_deal();
    deal = 1'b1;
    @(negedge clk);
    deal = 1'b0;
    n_checks++;
    if (err !== 1'b1 || dealt !== 1'b0)
      begin n_fail++; $display("FAIL empty_deal: err=%b dealt=%b expected 1 0", err, dealt); end
    n_checks++;
    if (rank !== 4'd13 || suit !== 2'd3 || remaining !== 8'd0)
      begin n_fail++; $display("FAIL empty_hold: rank=%0d suit=%0d remaining=%0d expected 13 3 0", rank, suit, remaining); end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0)
      begin n_fail++; $display("FAIL err_pulse: err=%b expected 0", err); end
  endtask

  task automatic test_shuffle_1234();
    int bad;
    int cnt [64];
    model_shuffle(16'h1234);
    run_shuffle_deal(16'h1234);
    n_checks++;
    if (got_timeout || got_cycles != exp_draws + N)
      begin n_fail++; $display("FAIL shuffle_duration: timeout=%b cycles=%0d expected %0d", got_timeout, got_cycles, exp_draws + N); end
    n_checks++;
    if (got_busy_at_done !== 1'b0 || got_all_dealt !== 1'b1)
      begin n_fail++; $display("FAIL shuffle_flags: busy_at_done=%b all_dealt=%b expected 0 1", got_busy_at_done, got_all_dealt); end
    bad = 0;
    for (int k = 0; k < N; k++) if (got_seq[k] !== exp_seq[k]) bad++;
    n_checks++;
    if (bad != 0)
      begin n_fail++; $display("FAIL shuffle_1234_sequence: %0d cards differ, expected 0", bad); end
    for (int c = 0; c < 64; c++) cnt[c] = 0;
    for (int k = 0; k < N; k++) cnt[got_seq[k]]++;
    bad = 0;
    for (int k = 0; k < 52; k++) if (cnt[ordered_card(k)] != NUM_DECKS) bad++;
    n_checks++;
    if (bad != 0)
      begin n_fail++; $display("FAIL shuffle_multiset: %0d card values with wrong count, expected 0", bad); end
    for (int k = 0; k < N; k++) seq_a[k] = got_seq[k];
  endtask

  task automatic test_shuffle_rerun();
    int bad;
    run_shuffle_deal(16'h1234);
    bad = 0;
    for (int k = 0; k < N; k++) if (got_seq[k] !== seq_a[k]) bad++;
    n_checks++;
    if (bad != 0)
      begin n_fail++; $display("FAIL shuffle_rerun: %0d cards differ from first run, expected 0", bad); end
  endtask

  task automatic test_shuffle_4321();
    int diff;
    int bad;
    model_shuffle(16'h4321);
    run_shuffle_deal(16'h4321);
    diff = 0; bad = 0;
    for (int k = 0; k < N; k++) begin
      if (got_seq[k] !== seq_a[k]) diff++;
      if (got_seq[k] !== exp_seq[k]) bad++;
    end
    n_checks++;
    if (diff == 0)
      begin n_fail++; $display("FAIL shuffle_seed_differs: %0d differences from seed 1234, expected nonzero", diff); end
    n_checks++;
    if (bad != 0)
      begin n_fail++; $display("FAIL shuffle_4321_sequence: %0d cards differ, expected 0", bad); end
  endtask

  task automatic test_seed_zero();
    logic [5:0] seq_b [N];
    int bad;
    int bad_model;
    model_shuffle(16'hACE1);
    run_shuffle_deal(16'hACE1);
    bad_model = 0;
    for (int k = 0; k < N; k++) begin
      seq_b[k] = got_seq[k];
      if (got_seq[k] !== exp_seq[k]) bad_model++;
    end
    n_checks++;
    if (bad_model != 0)
      begin n_fail++; $display("FAIL shuffle_ace1_sequence: %0d cards differ, expected 0", bad_model); end
    run_shuffle_deal(16'h0000);
    bad = 0;
    for (int k = 0; k < N; k++) if (got_seq[k] !== seq_b[k]) bad++;
    n_checks++;
    if (bad != 0 || got_timeout)
      begin n_fail++; $display("FAIL seed_zero: %0d cards differ from seed ACE1 (timeout=%b), expected 0", bad, got_timeout); end
  endtask

  task automatic test_back_to_back();
    do_reset_init();
    deal = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dealt !== 1'b1 || {rank, suit} !== ordered_card(0))
      begin n_fail++; $display("FAIL b2b_first: dealt=%b card=%h expected 1 %h", dealt, {rank, suit}, ordered_card(0)); end
    @(negedge clk);
    deal = 1'b0;
    n_checks++;
    if (dealt !== 1'b0 || err !== 1'b1 || remaining !== 8'(N - 1))
      begin n_fail++; $display("FAIL b2b_reject: dealt=%b err=%b remaining=%0d expected 0 1 %0d", dealt, err, remaining, N - 1); end
    deal = 1'b1;
    @(negedge clk);
    deal = 1'b0;
    n_checks++;
    if (dealt !== 1'b1 || {rank, suit} !== ordered_card(1) || remaining !== 8'(N - 2))
      begin n_fail++; $display("FAIL b2b_second: dealt=%b card=%h remaining=%0d expected 1 %h %0d", dealt, {rank, suit}, remaining, ordered_card(1), N - 2); end
    @(negedge clk);
  endtask

  task automatic test_deal_and_shuffle();
    int  cnt;
    bit  saw_dealt;
    do_reset_init();
    seed = 16'h1234; deal = 1'b1; shuffle = 1'b1;
    @(negedge clk);
    deal = 1'b0; shuffle = 1'b0;
    n_checks++;
    if (err !== 1'b1 || dealt !== 1'b0 || busy !== 1'b1)
      begin n_fail++; $display("FAIL deal_shuffle_collide: err=%b dealt=%b busy=%b expected 1 0 1", err, dealt, busy); end
    deal = 1'b1;
    @(negedge clk);
    deal = 1'b0;
    n_checks++;
    if (err !== 1'b1 || dealt !== 1'b0)
      begin n_fail++; $display("FAIL deal_while_busy: err=%b dealt=%b expected 1 0", err, dealt); end
    cnt = 0; saw_dealt = 1'b0;
    while (!shuffled && cnt < 6000) begin
      if (dealt) saw_dealt = 1'b1;
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (!shuffled || saw_dealt || remaining !== 8'(N))
      begin n_fail++; $display("FAIL collide_shuffle_done: shuffled=%b saw_dealt=%b remaining=%0d expected 1 0 %0d", shuffled, saw_dealt, remaining, N); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shuffle();
    int cnt;
    bit saw_done;
    do_reset_init();
    seed = 16'h4321; shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    repeat (50) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1 || remaining !== 8'd0 || shuffled !== 1'b0 || dealt !== 1'b0 || low_shoe !== 1'b0)
      begin n_fail++; $display("FAIL midreset_ctrl: busy=%b remaining=%0d shuffled=%b dealt=%b low=%b expected 1 0 0 0 0", busy, remaining, shuffled, dealt, low_shoe); end
    @(negedge clk);
    reset = 1'b1;
    cnt = 0; saw_done = 1'b0;
    while (busy && cnt < 1000) begin
      if (shuffled || dealt) saw_done = 1'b1;
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != N || saw_done)
      begin n_fail++; $display("FAIL midreset_init: init_cycles=%0d stray_pulse=%b expected %0d 0", cnt, saw_done, N); end
    for (int k = 0; k < 5; k++) begin
      deal = 1'b1;
      @(negedge clk);
      deal = 1'b0;
      n_checks++;
      if (dealt !== 1'b1 || {rank, suit} !== ordered_card(k))
        begin n_fail++; $display("FAIL midreset_order[%0d]: dealt=%b card=%h expected 1 %h", k, dealt, {rank, suit}, ordered_card(k)); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_ordered_deal();
    test_empty_deal();
    test_shuffle_1234();
    test_shuffle_rerun();
    test_shuffle_4321();
    test_seed_zero();
    test_back_to_back();
    test_deal_and_shuffle();
    test_reset_mid_shuffle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/poker_shoe.md
# poker_shoe

Parametrised multi-deck card source for the video-poker datapath, the next generation of the single-deck `deck` block. It holds NUM_DECKS × 52 cards in an on-chip register array, shuffles them in place with an LFSR-driven Fisher-Yates pass, and deals one card per request over the same deal/dealt and shuffle/shuffled handshakes that `play` and `resolver` already use. It adds multi-deck shoes, a cut-card low-shoe warning, exhaustion and error reporting, and a zero-seed guard.

## Interface
- NUM_DECKS, 1: decks in the shoe, 1..4; N = 52·NUM_DECKS cards.
- CUT_REMAIN, 10: `low_shoe` asserts when remaining cards ≤ CUT_REMAIN.
- SEED_W, 16: LFSR and seed width.
- DEFAULT_SEED, 16'hACE1: substituted when `seed` is 0.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- deal  in  1  one-cycle deal request.
- shuffle  in  1  one-cycle shuffle request.
- seed  in  SEED_W  LFSR seed, sampled on the cycle `shuffle` is accepted.
- dealt  out  1  one-cycle pulse; `rank`/`suit` valid in this cycle.
- rank  out  4  1=A, 2..10, 11=J, 12=Q, 13=K; held until the next `dealt`.
- suit  out  2  0..3.
- shuffled  out  1  one-cycle pulse at shuffle completion.
- busy  out  1  high in INIT and during a shuffle.
- remaining  out  8  undealt cards, 0..N.
- low_shoe  out  1  `remaining` ≤ CUT_REMAIN.
- err  out  1  one-cycle pulse when a request is rejected.

## Operation
- Storage: N × 6-bit array {rank, suit}. Index ptr (next card), shuffle index i, candidate j, each IDX_W = clog2(N) bits.
- Ordered layout: card k has c = k mod 52, suit = c/13, rank = (c mod 13)+1. INIT writes this using rank/suit/deck counters. No divider.
- LFSR: Galois, maximal-length for SEED_W (16: taps 16,14,13,11). Loaded with `seed`, or DEFAULT_SEED if `seed` is 0. Advances once per SH_DRAW cycle.
- State machine:
  - INIT: write card ptr, ptr++. After N cycles: ptr=0, remaining=N, go to IDLE.
  - IDLE: `shuffle` → load LFSR, i=N-1, go to SH_DRAW. `deal` with remaining>0 → DEAL. `deal` with remaining=0 → `err` pulse, stay in IDLE.
  - DEAL: dealt=1, {rank,suit} driven from the card at ptr, ptr++, remaining--, return to IDLE.
  - SH_DRAW: j = LFSR[IDX_W-1:0] (value before the advance). If j ≤ i go to SH_SWAP, else stay (rejection sampling, unbiased).
  - SH_SWAP: swap mem[i] and mem[j] in one cycle (j = i is allowed). If i = 1: ptr=0, remaining=N, shuffled=1, go to IDLE. Otherwise i--, go to SH_DRAW.
- Requests: `deal` and `shuffle` are accepted only in IDLE.
  - `deal` or `shuffle` outside IDLE (INIT, DEAL, SH_*) → ignored, `err` pulse.
  - `deal` and `shuffle` together in IDLE → shuffle wins, deal dropped, `err` pulse.
- A shuffle permutes the current array contents, so the multiset of cards is always exactly NUM_DECKS copies of each card.
- Dealing never wraps. Once remaining = 0, only a shuffle refills the shoe.

## Timing
- Reset values: dealt=0, shuffled=0, err=0, rank=0, suit=0, remaining=0, low_shoe=0, busy=1, state=INIT. The array is not reset; INIT rewrites it.
- INIT takes N cycles after reset release. `busy` drops in the first IDLE cycle.
- Deal latency: `deal` in IDLE at cycle t → `dealt` at t+1, `remaining` updates at t+1. The earliest next accepted `deal` is t+2 (a deal every other cycle).
- Shuffle: `busy` high from t+1. Duration = (N-1) SH_SWAP cycles plus the SH_DRAW cycles, variable and ≥ 2(N-1). `shuffled` and `busy`=0 occur in the same cycle.
- `low_shoe` is registered from the updated `remaining` in the same cycle as `dealt`.
- Reset asserted mid-shuffle or mid-deal: all state is lost, outputs take reset values, INIT repeats, and no `shuffled`/`dealt` is emitted for the aborted operation.

## Test plan
- Reset with NUM_DECKS=1 → `busy` high for 52 cycles. Then 52 deals, no shuffle → A♠0,2♠0…K(suit 3) in order, remaining 51→0, low_shoe first high at remaining=10.
- 53rd deal with remaining=0 → `err` pulse, no `dealt`, rank/suit unchanged.
- NUM_DECKS=2, shuffle with seed=16'h1234, deal 104 → each {rank,suit} appears exactly twice. The sequence is identical on a rerun with the same seed and differs with seed=16'h4321.
- seed=0 → same dealt sequence as seed=16'hACE1.
- `deal` and `shuffle` in the same IDLE cycle → `err`, a shuffle runs, no `dealt`. `deal` while busy → `err`.
- Reset pulse midway through a shuffle → reset values within the cycle, INIT reruns, then an ordered deal sequence.
